// File: rtl/draw_rect_img_if.sv
// VGA timing and colour bundle handed from one drawing stage to the next.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_img.sv
// Overlays a ROM-backed WIDTHxHEIGHT image on the VGA stream at a position latched once per frame.
// Stage 1 issues the ROM read; stage 2 chooses blank, image or background colour.
module draw_rect_img #(
  parameter int          WIDTH      = 64,
  parameter int          HEIGHT     = 64,
  parameter int          ADDR_W     = 12,
  parameter int          TRANSP_EN  = 1,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       rgb_pixel,
  vga_if.in                 in,
  vga_if.out                out
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [11:0]   xpos_l;
  logic [11:0]   ypos_l;
  logic          frame_start;
  logic [11:0]   x_cur;
  logic [11:0]   y_cur;
  logic [12:0]   h_ext;
  logic [12:0]   v_ext;
  logic [12:0]   x_lo;
  logic [12:0]   y_lo;
  logic [12:0]   x_hi;
  logic [12:0]   y_hi;
  logic          in_rect;
  logic [XW-1:0] rel_x;
  logic [YW-1:0] rel_y;

  logic [10:0]   hcount_d1;
  logic [10:0]   vcount_d1;
  logic          hsync_d1;
  logic          vsync_d1;
  logic          hblnk_d1;
  logic          vblnk_d1;
  logic [11:0]   rgb_d1;
  logic          in_rect_d1;

  logic          show_image;
  logic [11:0]   rgb_next;

  assign frame_start = (in.hcount == 11'd0) && (in.vcount == 11'd0);

  // The (0,0) pixel already uses the new position, one edge before the shadow holds it.
  assign x_cur = frame_start ? xpos : xpos_l;
  assign y_cur = frame_start ? ypos : ypos_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_l <= '0;
      ypos_l <= '0;
    end else if (frame_start) begin
      xpos_l <= xpos;
      ypos_l <= ypos;
    end
  end

  // 13-bit compare so x+WIDTH never wraps back into the visible area.
  assign h_ext = {2'b00, in.hcount};
  assign v_ext = {2'b00, in.vcount};
  assign x_lo  = {1'b0, x_cur};
  assign y_lo  = {1'b0, y_cur};
  assign x_hi  = x_lo + 13'(WIDTH);
  assign y_hi  = y_lo + 13'(HEIGHT);

  assign in_rect = (h_ext >= x_lo) && (h_ext < x_hi) &&
                   (v_ext >= y_lo) && (v_ext < y_hi);

  // Only the low bits of the offsets matter, so subtract just those bits.
  assign rel_x = in.hcount[XW-1:0] - x_cur[XW-1:0];
  assign rel_y = in.vcount[YW-1:0] - y_cur[YW-1:0];

  assign pixel_addr = in_rect ? ADDR_W'({rel_y, rel_x}) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_d1  <= '0;
      vcount_d1  <= '0;
      hsync_d1   <= 1'b0;
      vsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      rgb_d1     <= '0;
      in_rect_d1 <= 1'b0;
    end else begin
      hcount_d1  <= in.hcount;
      vcount_d1  <= in.vcount;
      hsync_d1   <= in.hsync;
      vsync_d1   <= in.vsync;
      hblnk_d1   <= in.hblnk;
      vblnk_d1   <= in.vblnk;
      rgb_d1     <= in.rgb;
      in_rect_d1 <= in_rect;
    end
  end

  assign show_image = in_rect_d1 &&
                      !((TRANSP_EN != 0) && (rgb_pixel == TRANSP_KEY));

  always_comb begin
    rgb_next = rgb_d1;
    if (hblnk_d1 || vblnk_d1) begin
      rgb_next = 12'h000;
    end else if (show_image) begin
      rgb_next = rgb_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= hcount_d1;
      out.vcount <= vcount_d1;
      out.hsync  <= hsync_d1;
      out.vsync  <= vsync_d1;
      out.hblnk  <= hblnk_d1;
      out.vblnk  <= vblnk_d1;
      out.rgb    <= rgb_next;
    end
  end
endmodule

// File: tb/tb_draw_rect_img.sv
// Directed bench for draw_rect_img: a frame-level model checks every output cycle,
// literal probes pin placement, addressing, transparency, frame latch, clipping and blanking.
module tb_draw_rect_img;
  localparam logic [11:0] BG = 12'h888;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb_t;
    logic [11:0] rgb_n;
  } exp_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic [11:0] addr_t;
  logic [11:0] addr_n;
  logic [11:0] pix_t = '0;
  logic [11:0] pix_n = '0;
  int          rom_mode = 0;
  int          checks = 0;
  int          errors = 0;
  int          sx = 0;
  int          sy = 0;
  exp_s        pend = '0;

  vga_if vin ();
  vga_if vout_t ();
  vga_if vout_n ();

  always #5 clk = ~clk;

  draw_rect_img #(.TRANSP_EN(1)) dut_t (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .pixel_addr(addr_t), .rgb_pixel(pix_t), .in(vin.in), .out(vout_t.out)
  );

  draw_rect_img #(.TRANSP_EN(0)) dut_n (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .pixel_addr(addr_n), .rgb_pixel(pix_n), .in(vin.in), .out(vout_n.out)
  );

  // ROM images: 0 solid green, 1 word = address, 2 solid green with the colour key at address 0.
  function automatic logic [11:0] rom_word(int mode, int a);
    if (mode == 1) return a[11:0];
    if (mode == 2 && a == 0) return 12'hF0F;
    return 12'h0F0;
  endfunction

  always @(posedge clk) begin
    pix_t <= rom_word(rom_mode, int'(addr_t));
    pix_n <= rom_word(rom_mode, int'(addr_n));
  end

  function automatic bit inside_img(int h, int v, int x, int y);
    return (h >= x) && (h < x + 64) && (v >= y) && (v < y + 64);
  endfunction

  function automatic exp_s model_pixel(int x, int y);
    exp_s        e;
    int          h;
    int          v;
    logic [11:0] w;
    h = int'(vin.hcount);
    v = int'(vin.vcount);
    e.h  = vin.hcount;
    e.v  = vin.vcount;
    e.hs = vin.hsync;
    e.vs = vin.vsync;
    e.hb = vin.hblnk;
    e.vb = vin.vblnk;
    if (vin.hblnk || vin.vblnk) begin
      e.rgb_t = 12'h000;
      e.rgb_n = 12'h000;
    end else if (!inside_img(h, v, x, y)) begin
      e.rgb_t = vin.rgb;
      e.rgb_n = vin.rgb;
    end else begin
      w = rom_word(rom_mode, (v - y) * 64 + (h - x));
      e.rgb_n = w;
      e.rgb_t = (w == 12'hF0F) ? vin.rgb : w;
    end
    return e;
  endfunction

  // Output compare: every cycle, outputs must show the input seen two edges earlier.
  always @(posedge clk) begin
    exp_s e;
    exp_s want;
    bit   r;
    int   x;
    int   y;
    r = rst;
    x = (vin.hcount == 11'd0 && vin.vcount == 11'd0) ? int'(xpos) : sx;
    y = (vin.hcount == 11'd0 && vin.vcount == 11'd0) ? int'(ypos) : sy;
    e = r ? '0 : model_pixel(x, y);
    sx = r ? 0 : x;
    sy = r ? 0 : y;
    #1;
    want = r ? '0 : pend;
    checks++;
    if ({vout_t.hcount, vout_t.vcount, vout_t.hsync, vout_t.vsync, vout_t.hblnk, vout_t.vblnk, vout_t.rgb}
        !== {want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.rgb_t}) begin
      errors++;
      $display("FAIL out_keyed: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h, want h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h",
               vout_t.hcount, vout_t.vcount, vout_t.hsync, vout_t.vsync, vout_t.hblnk, vout_t.vblnk, vout_t.rgb,
               want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.rgb_t);
    end
    checks++;
    if ({vout_n.hcount, vout_n.vcount, vout_n.hsync, vout_n.vsync, vout_n.hblnk, vout_n.vblnk, vout_n.rgb}
        !== {want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.rgb_n}) begin
      errors++;
      $display("FAIL out_nokey: got h=%0d v=%0d rgb=%h, want h=%0d v=%0d rgb=%h",
               vout_n.hcount, vout_n.vcount, vout_n.rgb, want.h, want.v, want.rgb_n);
    end
    pend = e;
  end

  // ROM address compare, mid-cycle once the inputs have settled.
  always @(negedge clk) begin
    int x;
    int y;
    int h;
    int v;
    int a;
    #2;
    if (!rst) begin
      h = int'(vin.hcount);
      v = int'(vin.vcount);
      x = (h == 0 && v == 0) ? int'(xpos) : sx;
      y = (h == 0 && v == 0) ? int'(ypos) : sy;
      a = inside_img(h, v, x, y) ? (v - y) * 64 + (h - x) : 0;
      checks++;
      if (addr_t !== 12'(a) || addr_n !== 12'(a)) begin
        errors++;
        $display("FAIL pixel_addr at (%0d,%0d): got %0d/%0d want %0d", h, v, addr_t, addr_n, a);
      end
    end
  end

  task automatic lit(string name, logic [11:0] got, logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(int h, int v, logic [11:0] bg);
    @(negedge clk);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = (h >= 800);
    vin.vblnk  = (v >= 600);
    vin.hsync  = (h >= 840) && (h < 968);
    vin.vsync  = (v >= 601) && (v < 605);
    vin.rgb    = bg;
  endtask

  // Drive one pixel, then a blanking filler, and read the result two edges later.
  task automatic probe(string name, int h, int v, logic [11:0] want_t, logic [11:0] want_n);
    drive(h, v, BG);
    drive(900, 620, BG);
    @(posedge clk);
    #2;
    $display("probe %s (%0d,%0d): keyed=%h nokey=%h", name, h, v, vout_t.rgb, vout_n.rgb);
    lit({name, "_keyed"}, vout_t.rgb, want_t);
    lit({name, "_nokey"}, vout_n.rgb, want_n);
    lit({name, "_hcount"}, 12'(vout_t.hcount), 12'(h));
  endtask

  task automatic scan(int v0, int v1, int h0, int h1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        drive(h, v, BG);
  endtask

  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    // Reset with random inputs, then release.
    for (int i = 0; i < 5; i++) begin
      xpos = 12'($urandom);
      ypos = 12'($urandom);
      drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 12'($urandom));
    end
    @(posedge clk);
    #2;
    lit("reset_rgb", vout_t.rgb, 12'h000);
    lit("reset_timing", {vout_t.hcount[5:0], vout_t.vcount[5:0]}, 12'h000);
    lit("reset_sync_blank", {8'h00, vout_t.hsync, vout_t.vsync, vout_t.hblnk, vout_t.vblnk}, 12'h000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      drive(int'($urandom_range(1, 1200)), int'($urandom_range(0, 700)), 12'($urandom));

    // Placement with a solid image.
    rom_mode = 0;
    xpos = 12'd100; ypos = 12'd50;
    drive(0, 0, BG);
    scan(48, 116, 96, 168);
    probe("place_tl", 100, 50, 12'h0F0, 12'h0F0);
    probe("place_br", 163, 113, 12'h0F0, 12'h0F0);
    probe("left_out", 99, 50, BG, BG);
    probe("right_out", 164, 50, BG, BG);
    probe("top_out", 100, 49, BG, BG);
    probe("bottom_out", 100, 114, BG, BG);

    // Addressing: ROM word equals its address.
    rom_mode = 1;
    drive(105, 52, BG);
    #1;
    lit("addr_105_52", addr_t, 12'd133);
    drive(900, 620, BG);
    @(posedge clk);
    #2;
    lit("addr_rgb", vout_t.rgb, 12'd133);

    // Transparency key at address 0.
    rom_mode = 2;
    probe("transp", 100, 50, BG, 12'hF0F);
    probe("opaque", 101, 50, 12'h0F0, 12'h0F0);

    // Mid-frame position change waits for the next frame.
    rom_mode = 0;
    xpos = 12'd300;
    drive(400, 200, BG);
    probe("latch_old_in", 120, 60, 12'h0F0, 12'h0F0);
    probe("latch_new_out", 310, 60, BG, BG);
    drive(0, 0, BG);
    probe("frame2_new_in", 310, 60, 12'h0F0, 12'h0F0);
    probe("frame2_old_out", 120, 60, BG, BG);
    xpos = 12'd0; ypos = 12'd0;
    probe("origin_same_pixel", 0, 0, 12'h0F0, 12'h0F0);

    // Clipping at the right edge, no wrap into low columns.
    xpos = 12'd1000; ypos = 12'd0;
    probe("clip_origin", 0, 0, BG, BG);
    scan(10, 10, 0, 70);
    scan(10, 10, 990, 1060);
    probe("clip_no_wrap", 5, 10, BG, BG);
    probe("clip_hblnk", 1010, 10, 12'h000, 12'h000);

    // Image overlapping blanking must be black.
    xpos = 12'd780; ypos = 12'd580;
    probe("blank_origin", 0, 0, BG, BG);
    probe("blank_visible", 790, 590, 12'h0F0, 12'h0F0);
    probe("blank_h", 810, 590, 12'h000, 12'h000);
    probe("blank_v", 790, 610, 12'h000, 12'h000);

    // Mid-frame reset flushes the pipeline and returns the shadow to (0,0).
    drive(790, 590, BG);
    rst = 1'b1;
    drive(795, 590, BG);
    drive(796, 590, BG);
    rst = 1'b0;
    probe("after_reset_shadow", 10, 10, 12'h0F0, 12'h0F0);
    drive(900, 620, BG);
    drive(900, 620, BG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_rect_img.md
# draw_rect_img

Pipelined drawing stage that overlays a WIDTH×HEIGHT image, fetched from an external synchronous image ROM, onto the VGA stream at a movable position (xpos, ypos). It sits directly downstream of the timing generator (or a background stage) and forwards the full timing bundle delayed to stay aligned with the RGB it produces. Position inputs are sampled once per frame so the image never tears mid-frame.

## Interface

Parameters:
- WIDTH, default 64: image width in pixels; must be a power of two, ≤ 2048.
- HEIGHT, default 64: image height in pixels; must be a power of two, ≤ 2048.
- ADDR_W, default 12: ROM address width; equals log2(WIDTH) + log2(HEIGHT).
- TRANSP_EN, default 1: when 1, image pixels equal to TRANSP_KEY show the background.
- TRANSP_KEY, default 12'hF0F: 12-bit colour key for transparency.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: synchronous, active-high reset.
- xpos, input, 12: requested image left column; may change at any time.
- ypos, input, 12: requested image top row; may change at any time.
- pixel_addr, output, ADDR_W: ROM read address, combinational from current inputs.
- rgb_pixel, input, 12: ROM data; valid one cycle after pixel_addr, i.e. ROM registers the address on the clk edge.
- in, vga_if.in: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].
- out, vga_if.out: the same fields, registered.

## Operation

- Position shadow: xpos_l/ypos_l load xpos/ypos on any edge where in.hcount==0 and in.vcount==0. They hold otherwise. Reset value is 0.
- The position update takes effect from that same pixel (0,0). The comparison uses the incoming xpos/ypos on that cycle, not the stale shadow.
- Hit test on input cycle, 13-bit unsigned arithmetic, no wrap:
  - in_rect = (hcount ≥ x) && (hcount < x+WIDTH) && (vcount ≥ y) && (vcount < y+HEIGHT).
  - Image columns beyond 2047 are simply never reached.
- rel_x = hcount − x and rel_y = vcount − y, truncated to log2 widths.
- pixel_addr = {rel_y, rel_x}. When in_rect=0, pixel_addr = 0; its value is don't-care but must be deterministic.
- Stage 1 registers: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, in_rect. These are internal `_d1` copies.
- Stage 2 output registers: all timing fields from `_d1`, plus out.rgb, selected in priority order:
  1. `hblnk_d1 | vblnk_d1` → 12'h000.
  2. `in_rect_d1 && !(TRANSP_EN && rgb_pixel==TRANSP_KEY)` → rgb_pixel.
  3. Otherwise → `rgb_d1` (background passes through).
- The block has no backpressure and no stall; it processes one pixel per clock, unconditionally.
- Reset: all outputs (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) are 0, and every pipeline register is 0. The first output after release is reset data for 2 cycles, then real data.
- Reset mid-frame: the pipeline flushes to 0 immediately. The shadow position returns to 0 until the next (0,0) pixel.

## Timing

- Latency from `in` to `out` is exactly 2 clk cycles for every field, including the RGB decision.
- Input pixel at cycle N: pixel_addr is valid in cycle N; rgb_pixel is valid in cycle N+1; out holds that pixel after edge N+2.
- Sync and blank pulse widths and relative alignments are preserved bit-exactly, only shifted by 2.
- xpos/ypos changes away from frame start have no visible effect until the next frame.
- Critical path: 13-bit compare plus address concat to the ROM. No multiplier is needed because WIDTH is a power of two.

## Test plan

- Reset: hold rst 5 cycles with random inputs → all out fields 0. Release → out equals in delayed by 2 cycles from cycle 3 onward.
- Placement: xpos=100, ypos=50, solid ROM 12'h0F0, background 12'h888.
  - out pixels (100..163, 50..113) = 12'h0F0.
  - Pixels (99,50), (164,50), (100,49) and (100,114) = 12'h888.
- Addressing: ROM content = address.
  - At hcount=105, vcount=52 → pixel_addr = {6'd2, 6'd5} = 12'd133.
  - out.rgb two cycles later = 12'd133.
- Transparency: ROM word 12'hF0F at addr 0, TRANSP_EN=1 → out at (100,50) = background 12'h888. Same test with TRANSP_EN=0 → 12'hF0F.
- Frame latch: change xpos 100→300 at (400,200) mid-frame.
  - The rest of the frame keeps the image at x=100.
  - The next frame places it at x=300 starting at pixel (0,0).
- Edge and blank:
  - xpos=1000 on an 800-wide visible area → image clipped, no wrap artifact at x<64.
  - Any in_rect pixel during hblnk/vblnk → out.rgb = 0.
